// File: rtl/conv_mac_ctrl_pkg.sv
// Shared types and constants for the serial convolution sequencer.
// Holds the state encoding, tap counts and weight-file type used by conv_mac_ctrl.
package packConv;

    localparam int NBITS = 20;
    localparam int TAPS3 = 9;
    localparam int TAPS5 = 25;
    localparam int TAP_W = 5;

    typedef enum logic [1:0] {IDLE, LOAD_W, MAC, OUT} conv_state_t;

    typedef logic signed [NBITS-1:0] param25 [0:TAPS5-1];
    // 3x3 jobs only use entries 0..8.
    typedef param25 regC;

    function automatic logic [TAP_W-1:0] lastTap(input logic mode);
        return mode ? TAP_W'(TAPS5 - 1) : TAP_W'(TAPS3 - 1);
    endfunction

endpackage

// File: rtl/conv_mac_ctrl_if.sv
// Job, weight, pixel and result signals of the serial convolution sequencer.
// A beat on any channel transfers on a rising edge where valid && ready; valid never waits on ready.
interface conv_mac_ctrl_if #(
    parameter int NBITS  = packConv::NBITS,
    parameter int WCNT_W = 16
);
    logic              start;
    logic              mode;
    logic [WCNT_W-1:0] n_windows;
    logic              w_valid;
    logic [NBITS-1:0]  w_data;
    logic              w_ready;
    logic              px_valid;
    logic [NBITS-1:0]  px_data;
    logic              px_ready;
    logic              res_valid;
    logic [NBITS-1:0]  res_data;
    logic              res_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, n_windows, w_valid, w_data, px_valid, px_data, res_ready,
        input  w_ready, px_ready, res_valid, res_data, busy, done
    );

    modport slave (
        input  start, mode, n_windows, w_valid, w_data, px_valid, px_data, res_ready,
        output w_ready, px_ready, res_valid, res_data, busy, done
    );
endinterface

// File: rtl/conv_mac_ctrl_mac_unit.sv
// Signed multiplier feeding a guard-bit accumulator, with clear and enable.
// Output stage wraps modulo 2^NBITS, or saturates when CONV_SAT_EN is defined.
module conv_mac_unit #(
    parameter int NBITS = 20
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [NBITS-1:0] pixel,
    input  logic signed [NBITS-1:0] weight,
    output logic        [NBITS-1:0] result
);
    localparam int ACC_W = 3 * NBITS + 5;

    logic signed [2*NBITS-1:0] product;
    logic signed [ACC_W-1:0]   acc;

    assign product = pixel * weight;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(product);
        end
    end

`ifdef CONV_SAT_EN
    // The sum fits in NBITS only when all bits from NBITS-1 upward agree.
    logic [ACC_W-NBITS:0] upper;
    assign upper = acc[ACC_W-1:NBITS-1];

    always_comb begin
        result = acc[NBITS-1:0];
        if (acc[ACC_W-1] && !(&upper)) begin
            result = {1'b1, {(NBITS-1){1'b0}}};
        end else if (!acc[ACC_W-1] && (|upper)) begin
            result = {1'b0, {(NBITS-1){1'b1}}};
        end
    end
`else
    assign result = acc[NBITS-1:0];
`endif

endmodule

// File: rtl/conv_mac_ctrl.sv
// Serial convolution sequencer: loads a 3x3/5x5 kernel, then MACs one tap per accepted pixel
// and hands one result per window to the writer. Saturating output with CONV_SAT_EN.
module conv_mac_ctrl
    import packConv::*;
#(
    parameter int NBITS  = 20,
    parameter int WCNT_W = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    conv_mac_ctrl_if.slave  bus,
    output conv_state_t     stateDbg
);
    localparam logic [WCNT_W-1:0] WIN_ONE = WCNT_W'(1);

    conv_state_t       state;
    logic              modeR;
    logic [WCNT_W-1:0] nWin;
    logic [WCNT_W-1:0] winCnt;
    logic [WCNT_W-1:0] winCntNext;
    logic [TAP_W-1:0]  tap;
    regC               weights;
    logic              wReadyR;
    logic              pxReadyR;
    logic              resValidR;
    logic              busyR;
    logic              doneR;

    logic wAccept;
    logic pxAccept;
    logic resAccept;
    logic isLastTap;
    logic isLastWin;
    logic macClr;
    logic macEn;
    logic [NBITS-1:0] macResult;

    assign wAccept    = bus.w_valid && wReadyR;
    assign pxAccept   = bus.px_valid && pxReadyR;
    assign resAccept  = resValidR && bus.res_ready;
    assign isLastTap  = (tap == lastTap(modeR));
    assign winCntNext = winCnt + WIN_ONE;
    assign isLastWin  = (winCntNext == nWin);

    // Accumulator restarts before the first window and after every delivered result.
    assign macClr = ((state == LOAD_W) && wAccept && isLastTap && (nWin != '0))
                 || ((state == OUT) && resAccept);
    assign macEn  = (state == MAC) && pxAccept;

    conv_mac_unit #(.NBITS(NBITS)) macUnit (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (macClr),
        .en      (macEn),
        .pixel   (bus.px_data),
        .weight  (weights[tap]),
        .result  (macResult)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            modeR     <= 1'b0;
            nWin      <= '0;
            winCnt    <= '0;
            tap       <= '0;
            weights   <= '{default: '0};
            wReadyR   <= 1'b0;
            pxReadyR  <= 1'b0;
            resValidR <= 1'b0;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
        end else begin
            doneR <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The empty-job done pulse is still in flight; a start there is dropped.
                    if (bus.start && !doneR) begin
                        modeR   <= bus.mode;
                        nWin    <= bus.n_windows;
                        winCnt  <= '0;
                        tap     <= '0;
                        wReadyR <= 1'b1;
                        busyR   <= 1'b1;
                        state   <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (wAccept) begin
                        weights[tap] <= bus.w_data;
                        if (isLastTap) begin
                            tap     <= '0;
                            wReadyR <= 1'b0;
                            if (nWin == '0) begin
                                busyR <= 1'b0;
                                doneR <= 1'b1;
                                state <= IDLE;
                            end else begin
                                pxReadyR <= 1'b1;
                                state    <= MAC;
                            end
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (pxAccept) begin
                        if (isLastTap) begin
                            pxReadyR  <= 1'b0;
                            resValidR <= 1'b1;
                            state     <= OUT;
                        end else begin
                            tap <= tap + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (resAccept) begin
                        resValidR <= 1'b0;
                        winCnt    <= winCntNext;
                        tap       <= '0;
                        if (isLastWin) begin
                            busyR <= 1'b0;
                            state <= IDLE;
                        end else begin
                            pxReadyR <= 1'b1;
                            state    <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.w_ready   = wReadyR;
    assign bus.px_ready  = pxReadyR;
    assign bus.res_valid = resValidR;
    assign bus.res_data  = macResult;
    assign bus.busy      = busyR;
    // Final-window done coincides with the last result handshake.
    assign bus.done      = doneR || ((state == OUT) && resAccept && isLastWin);
    assign stateDbg      = state;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Bench for conv_mac_ctrl: directed and random jobs scored against a sum-of-products model.
// Build with +define+CONV_SAT_EN to score the saturating variant.
`timescale 1ns/1ps
module tb_conv_mac_ctrl;
  import packConv::*;

  localparam int NB = 20;
  localparam int WW = 16;
  localparam longint MAXV = (longint'(1) << (NB - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (NB - 1));

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  conv_state_t state_dbg;

  conv_mac_ctrl_if #(.NBITS(NB), .WCNT_W(WW)) bus();

  conv_mac_ctrl #(.NBITS(NB), .WCNT_W(WW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .stateDbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  int bp_hold = 0;
  bit rnd_ready = 1'b1;
  bit gaps = 1'b1;
  logic [NB-1:0] exp_q[$];
  logic signed [NB-1:0] w_arr[25];
  logic signed [NB-1:0] px_arr[4][25];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected result of window w: plain sum of products, then wrap or clamp.
  function automatic logic [NB-1:0] model_res(input bit m, input int w);
    longint s = 0;
    int n = m ? 25 : 9;
    for (int t = 0; t < n; t++) s += longint'(w_arr[t]) * longint'(px_arr[w][t]);
`ifdef CONV_SAT_EN
    if (s > MAXV) s = MAXV;
    else if (s < MINV) s = MINV;
`endif
    return s[NB-1:0];
  endfunction

  function automatic logic [NB-1:0] rand_val();
    case ($urandom_range(0, 3))
      0: return 20'h7FFFF;
      1: return 20'h80000;
      default: return NB'($urandom);
    endcase
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic held_v = 1'b0;
    logic [NB-1:0] held_d = '0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (held_v) begin
          check("hold_valid", bus.res_valid, 1);
          check("hold_data", bus.res_data, held_d);
        end
        if (bus.res_valid) begin
          check("px_ready_in_out", bus.px_ready, 0);
          check("w_ready_in_out", bus.w_ready, 0);
          if (!bus.res_ready) stall_cnt++;
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexp_res: got 0x%0h expected no result", bus.res_data);
          end else begin
            check("res_data", bus.res_data, exp_q.pop_front());
          end
        end
        if (bus.done) begin
          done_cnt++;
          check("done_after_last_res", exp_q.size(), 0);
        end
        held_v = bus.res_valid && !bus.res_ready;
        held_d = bus.res_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- result consumer ----------------
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (bp_hold > 0) begin
        bus.res_ready = 1'b0;
        if (bus.res_valid) bp_hold--;
      end else if (rnd_ready) begin
        bus.res_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.res_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit m, input int nw);
    bus.start = 1'b1;
    bus.mode = m;
    bus.n_windows = WW'(nw);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic send_weight(input logic [NB-1:0] d);
    int k = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      bus.w_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    bus.w_valid = 1'b1;
    bus.w_data = d;
    @(negedge clock);
    while (!bus.w_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("w_accept_in_time", k < 200, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic send_pixel(input logic [NB-1:0] d);
    int k = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      bus.px_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    bus.px_valid = 1'b1;
    bus.px_data = d;
    @(negedge clock);
    while (!bus.px_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("px_accept_in_time", k < 200, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clock);
    while (bus.busy && k < 5000) begin
      @(negedge clock);
      k++;
    end
    check("job_end_in_time", k < 5000, 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic run_job(input bit m, input int nw, input bit poke);
    int n = m ? 25 : 9;
    int d0 = done_cnt;
    for (int w = 0; w < nw; w++) exp_q.push_back(model_res(m, w));
    pulse_start(m, nw);
    check("busy_rise", bus.busy, 1);
    for (int t = 0; t < n; t++) begin
      if (poke && t == 3) begin
        bus.w_valid = 1'b0;
        pulse_start(!m, 7);
      end
      send_weight(w_arr[t]);
    end
    bus.w_valid = 1'b0;
    for (int w = 0; w < nw; w++)
      for (int t = 0; t < n; t++) send_pixel(px_arr[w][t]);
    bus.px_valid = 1'b0;
    wait_idle();
    check("done_once", done_cnt - d0, 1);
    check("all_results_seen", exp_q.size(), 0);
    check("busy_low_after", bus.busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st0;
    int d0;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.n_windows = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.px_valid = 1'b0;
    bus.px_data = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_w_ready", bus.w_ready, 0);
    check("rst_px_ready", bus.px_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_state", state_dbg, IDLE);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 3x3 basic: weights 1, pixels 1..9
    for (int t = 0; t < 25; t++) begin
      w_arr[t] = 1;
      px_arr[0][t] = NB'(t + 1);
    end
    check("model_3x3", model_res(0, 0), 45);
    run_job(0, 1, 0);

    // 5x5, two windows: weights 2, window A 1..25, window B zero
    for (int t = 0; t < 25; t++) begin
      w_arr[t] = 2;
      px_arr[0][t] = NB'(t + 1);
      px_arr[1][t] = 0;
    end
    check("model_5x5_a", model_res(1, 0), 650);
    check("model_5x5_b", model_res(1, 1), 0);
    run_job(1, 2, 0);

    // Overflow: weights 0x7FFFF, pixels 2
    for (int t = 0; t < 25; t++) begin
      w_arr[t] = 20'h7FFFF;
      px_arr[0][t] = 2;
    end
`ifdef CONV_SAT_EN
    check("model_ovf", model_res(0, 0), 20'h7FFFF);
`else
    check("model_ovf", model_res(0, 0), 20'hFFFEE);
`endif
    run_job(0, 1, 0);

    // Backpressure: res_ready held low for 5 cycles of res_valid
    for (int t = 0; t < 25; t++) begin
      w_arr[t] = rand_val();
      px_arr[0][t] = rand_val();
      px_arr[1][t] = rand_val();
    end
    gaps = 1'b0;
    rnd_ready = 1'b0;
    bp_hold = 5;
    st0 = stall_cnt;
    run_job(0, 2, 0);
    check("bp_stall_cycles", stall_cnt - st0, 5);
    gaps = 1'b1;
    rnd_ready = 1'b1;

    // Reset after the 4th weight of a 3x3 load
    d0 = done_cnt;
    pulse_start(0, 1);
    for (int t = 0; t < 4; t++) send_weight(NB'(t + 5));
    bus.w_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_w_ready", bus.w_ready, 0);
    check("mid_rst_px_ready", bus.px_ready, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    for (int t = 0; t < 25; t++) begin
      w_arr[t] = 1;
      px_arr[0][t] = 3;
    end
    check("model_after_rst", model_res(0, 0), 27);
    run_job(0, 1, 0);

    // Empty job with a stray start during the load
    for (int t = 0; t < 25; t++) w_arr[t] = rand_val();
    run_job(0, 0, 1);

    // Random jobs, some with a stray start mid-load
    for (int j = 0; j < 8; j++) begin
      bit m = 1'($urandom_range(0, 1));
      int nw = $urandom_range(1, 3);
      for (int t = 0; t < 25; t++) begin
        w_arr[t] = rand_val();
        for (int w = 0; w < 4; w++) px_arr[w][t] = rand_val();
      end
      run_job(m, nw, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
